// File: rtl/mem_sched.sv
// Memory-controller access scheduler: one display reader with line-rate priority, two
// round-robin capture writers, gap insertion and underrun counting. Optional macro: SCHED_TIMEOUT_EN.
module mem_sched #(
  parameter int TIMEOUT = 2048,
  parameter int GAP_CYC = 1
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       hs,
  input  logic       vs,
  input  logic       wr0_req,
  input  logic       wr1_req,
  input  logic       rd_donep,
  input  logic       wr0_donep,
  input  logic       wr1_donep,
  output logic       rd_en,
  output logic       wr0_en,
  output logic       wr1_en,
  output logic [1:0] arb_state,
  output logic       rd_miss,
  output logic [7:0] miss_cnt,
  output logic       tout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR0  = 3'd2,
    WR1  = 3'd3,
    GAP  = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYC - 1);

  state_t     state;
  logic       hs_q;
  logic       vs_q;
  logic       rd_pend;
  logic       rr_ptr;     // 0: writer 0 preferred, 1: writer 1 preferred
  logic [3:0] gap_cnt;

  logic line_edge_s;
  logic frame_edge_s;
  logic miss_evt_s;
  logic owner_done_s;
  logic expire_s;
  logic pick_wr0_s;
  logic pick_wr1_s;

  assign line_edge_s  = hs & ~hs_q;
  assign frame_edge_s = vs & ~vs_q;
  assign miss_evt_s   = line_edge_s & (rd_pend | (state == RD));
  assign pick_wr0_s   = wr0_req & (~wr1_req | ~rr_ptr);
  assign pick_wr1_s   = wr1_req & ~pick_wr0_s;

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;

  // Grant-length counter, restarted on every new grant
  always_ff @(posedge pclk) begin
    if (rst) begin
      tcnt <= '0;
    end else if (state == IDLE) begin
      tcnt <= '0;
    end else if (state == RD || state == WR0 || state == WR1) begin
      tcnt <= tcnt + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tcnt <= tcnt;
    end
  end

  assign expire_s = (state == RD || state == WR0 || state == WR1) && (tcnt == T_LAST) && !owner_done_s;
`else
  assign expire_s = 1'b0;
`endif

  // Only the current owner's done is meaningful
  always_comb begin
    owner_done_s = 1'b0;
    case (state)
      RD:      owner_done_s = rd_donep;
      WR0:     owner_done_s = wr0_donep;
      WR1:     owner_done_s = wr1_donep;
      default: owner_done_s = 1'b0;
    endcase
  end

  // Scheduler FSM with registered grants, owner code and miss bookkeeping
  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= IDLE;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      rd_pend   <= 1'b0;
      rr_ptr    <= 1'b0;
      gap_cnt   <= 4'd0;
      rd_en     <= 1'b0;
      wr0_en    <= 1'b0;
      wr1_en    <= 1'b0;
      arb_state <= 2'b00;
      rd_miss   <= 1'b0;
      miss_cnt  <= 8'd0;
      tout      <= 1'b0;
    end else begin
      hs_q    <= hs;
      vs_q    <= vs;
      rd_miss <= miss_evt_s;
      tout    <= 1'b0;
      // A miss coincident with a frame edge survives the clear as a count of one
      if (frame_edge_s) begin
        miss_cnt <= {7'd0, miss_evt_s};
      end else if (miss_evt_s && miss_cnt != 8'hFF) begin
        miss_cnt <= miss_cnt + 8'd1;
      end else begin
        miss_cnt <= miss_cnt;
      end
      rd_pend <= line_edge_s | (rd_pend & ~(state == IDLE));

      case (state)
        IDLE: begin
          if (rd_pend) begin
            state     <= RD;
            rd_en     <= 1'b1;
            arb_state <= 2'b00;
          end else if (pick_wr0_s) begin
            state     <= WR0;
            wr0_en    <= 1'b1;
            arb_state <= 2'b01;
            rr_ptr    <= 1'b1;
          end else if (pick_wr1_s) begin
            state     <= WR1;
            wr1_en    <= 1'b1;
            arb_state <= 2'b10;
            rr_ptr    <= 1'b0;
          end else begin
            state     <= IDLE;
            arb_state <= 2'b00;
          end
        end
        RD, WR0, WR1: begin
          if (owner_done_s || expire_s) begin
            state     <= GAP;
            rd_en     <= 1'b0;
            wr0_en    <= 1'b0;
            wr1_en    <= 1'b0;
            arb_state <= 2'b11;
            gap_cnt   <= GAP_LOAD;
            tout      <= expire_s;
          end else begin
            state <= state;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            state     <= IDLE;
            arb_state <= 2'b00;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          rd_en     <= 1'b0;
          wr0_en    <= 1'b0;
          wr1_en    <= 1'b0;
          arb_state <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sched.sv
// Directed self-checking bench for mem_sched (GAP_CYC=1, TIMEOUT=16); build with or without SCHED_TIMEOUT_EN.
module tb_mem_sched;
  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       hs = 1'b0, vs = 1'b0;
  logic       wr0_req = 1'b0, wr1_req = 1'b0;
  logic       rd_donep = 1'b0, wr0_donep = 1'b0, wr1_donep = 1'b0;
  logic       rd_en, wr0_en, wr1_en;
  logic [1:0] arb_state;
  logic       rd_miss;
  logic [7:0] miss_cnt;
  logic       tout;

  int checks = 0;
  int errors = 0;

  mem_sched #(.TIMEOUT(16), .GAP_CYC(1)) dut (
    .pclk(pclk), .rst(rst), .hs(hs), .vs(vs),
    .wr0_req(wr0_req), .wr1_req(wr1_req),
    .rd_donep(rd_donep), .wr0_donep(wr0_donep), .wr1_donep(wr1_donep),
    .rd_en(rd_en), .wr0_en(wr0_en), .wr1_en(wr1_en),
    .arb_state(arb_state), .rd_miss(rd_miss), .miss_cnt(miss_cnt), .tout(tout)
  );

  always #5 pclk = ~pclk;

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++;
    if ({rd_en, wr0_en, wr1_en, arb_state, rd_miss, miss_cnt, tout} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b%b%b arb=%b miss=%b cnt=%0d tout=%b, want all zero",
               rd_en, wr0_en, wr1_en, arb_state, rd_miss, miss_cnt, tout);
    end
    rst = 1'b0;
    tick; tick;
    checks++;
    if ({rd_en, wr0_en, wr1_en, arb_state} !== 5'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got en=%b%b%b arb=%b, want 000/00", rd_en, wr0_en, wr1_en, arb_state);
    end
  endtask

  task automatic test_read_grant;
    hs = 1'b1;            // line edge in cycle N
    tick;                 // N+1
    hs = 1'b0;
    checks++;
    if (rd_en !== 1'b0) begin errors++; $display("FAIL rd_early: got rd_en=%b, want 0", rd_en); end
    tick;                 // N+2
    checks++;
    if (rd_en !== 1'b1 || arb_state !== 2'b00) begin
      errors++; $display("FAIL rd_grant: got rd_en=%b arb=%b, want 1/00", rd_en, arb_state);
    end
    repeat (8) tick;      // N+10
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL rd_hold: got rd_en=%b, want 1", rd_en); end
    rd_donep = 1'b1;
    tick;                 // N+11
    rd_donep = 1'b0;
    checks++;
    if (rd_en !== 1'b0 || arb_state !== 2'b11) begin
      errors++; $display("FAIL rd_release: got rd_en=%b arb=%b, want 0/11", rd_en, arb_state);
    end
    tick;                 // N+12
    checks++;
    if (arb_state !== 2'b00 || {rd_en, wr0_en, wr1_en} !== 3'b000) begin
      errors++; $display("FAIL rd_back_idle: got arb=%b en=%b%b%b, want 00/000", arb_state, rd_en, wr0_en, wr1_en);
    end
  endtask

  task automatic test_writer_rr;
    wr0_req = 1'b1; wr1_req = 1'b1;
    tick;
    checks++;
    if (wr0_en !== 1'b1 || wr1_en !== 1'b0 || arb_state !== 2'b01) begin
      errors++; $display("FAIL rr_first_wr0: got wr0=%b wr1=%b arb=%b, want 1/0/01", wr0_en, wr1_en, arb_state);
    end
    wr0_donep = 1'b1;
    tick;
    wr0_donep = 1'b0;
    checks++;
    if (wr0_en !== 1'b0 || arb_state !== 2'b11) begin
      errors++; $display("FAIL rr_gap1: got wr0=%b arb=%b, want 0/11", wr0_en, arb_state);
    end
    tick;                 // IDLE decision
    tick;
    checks++;
    if (wr1_en !== 1'b1 || wr0_en !== 1'b0 || arb_state !== 2'b10) begin
      errors++; $display("FAIL rr_second_wr1: got wr0=%b wr1=%b arb=%b, want 0/1/10", wr0_en, wr1_en, arb_state);
    end
    rd_donep = 1'b1; wr0_donep = 1'b1;
    tick;
    rd_donep = 1'b0; wr0_donep = 1'b0;
    checks++;
    if (wr1_en !== 1'b1 || arb_state !== 2'b10) begin
      errors++; $display("FAIL foreign_done: got wr1=%b arb=%b, want 1/10", wr1_en, arb_state);
    end
    wr1_donep = 1'b1;
    tick;
    wr1_donep = 1'b0;
    checks++;
    if (arb_state !== 2'b11 || wr1_en !== 1'b0) begin
      errors++; $display("FAIL rr_gap2: got wr1=%b arb=%b, want 0/11", wr1_en, arb_state);
    end
    tick; tick;
    checks++;
    if (wr0_en !== 1'b1 || arb_state !== 2'b01) begin
      errors++; $display("FAIL rr_third_wr0: got wr0=%b arb=%b, want 1/01", wr0_en, arb_state);
    end
    wr0_req = 1'b0; wr1_req = 1'b0;
    tick;
    checks++;
    if (wr0_en !== 1'b1) begin errors++; $display("FAIL req_drop_hold: got wr0=%b, want 1", wr0_en); end
    wr0_donep = 1'b1;
    tick;
    wr0_donep = 1'b0;
    tick; tick; tick;
    checks++;
    if ({rd_en, wr0_en, wr1_en} !== 3'b000 || arb_state !== 2'b00) begin
      errors++; $display("FAIL no_req_no_grant: got en=%b%b%b arb=%b, want 000/00", rd_en, wr0_en, wr1_en, arb_state);
    end
  endtask

  task automatic test_read_priority;
    wr0_req = 1'b1;
    tick;
    checks++;
    if (wr0_en !== 1'b1) begin errors++; $display("FAIL prio_wr0_grant: got wr0=%b, want 1", wr0_en); end
    wr1_req = 1'b1; hs = 1'b1;   // line edge during WR0
    tick;
    hs = 1'b0;
    checks++;
    if (rd_miss !== 1'b0 || wr0_en !== 1'b1) begin
      errors++; $display("FAIL prio_no_miss: got rd_miss=%b wr0=%b, want 0/1", rd_miss, wr0_en);
    end
    wr0_donep = 1'b1;
    tick;
    wr0_donep = 1'b0; wr0_req = 1'b0;
    tick; tick;
    checks++;
    if (rd_en !== 1'b1 || wr1_en !== 1'b0 || arb_state !== 2'b00) begin
      errors++; $display("FAIL prio_rd_first: got rd=%b wr1=%b arb=%b, want 1/0/00", rd_en, wr1_en, arb_state);
    end
    rd_donep = 1'b1; wr1_req = 1'b0;
    tick;
    rd_donep = 1'b0;
    tick; tick; tick;
    checks++;
    if ({rd_en, wr0_en, wr1_en} !== 3'b000 || arb_state !== 2'b00) begin
      errors++; $display("FAIL prio_idle: got en=%b%b%b arb=%b, want 000/00", rd_en, wr0_en, wr1_en, arb_state);
    end
  endtask

  task automatic test_miss;
    hs = 1'b1; tick; hs = 1'b0; tick;
    checks++;
    if (rd_en !== 1'b1) begin errors++; $display("FAIL miss_rd_grant: got rd_en=%b, want 1", rd_en); end
    for (int i = 0; i < 3; i++) begin
      hs = 1'b1;
      tick;
      hs = 1'b0;
      checks++;
      if (rd_miss !== 1'b1) begin errors++; $display("FAIL miss_pulse%0d: got rd_miss=%b, want 1", i, rd_miss); end
      tick;
      checks++;
      if (rd_miss !== 1'b0) begin errors++; $display("FAIL miss_pulse_end%0d: got rd_miss=%b, want 0", i, rd_miss); end
    end
    checks++;
    if (miss_cnt !== 8'd3) begin errors++; $display("FAIL miss_cnt3: got %0d, want 3", miss_cnt); end
    vs = 1'b1;
    tick;
    vs = 1'b0;
    checks++;
    if (miss_cnt !== 8'd0 || rd_en !== 1'b1) begin
      errors++; $display("FAIL frame_clear: got cnt=%0d rd_en=%b, want 0/1", miss_cnt, rd_en);
    end
    tick;
    vs = 1'b1; hs = 1'b1;
    tick;
    vs = 1'b0; hs = 1'b0;
    checks++;
    if (miss_cnt !== 8'd1 || rd_miss !== 1'b1) begin
      errors++; $display("FAIL frame_and_miss: got cnt=%0d rd_miss=%b, want 1/1", miss_cnt, rd_miss);
    end
    tick;
    rd_donep = 1'b1;
    repeat (5) tick;
    rd_donep = 1'b0;
    repeat (3) tick;
    checks++;
    if (rd_en !== 1'b0 || arb_state !== 2'b00) begin
      errors++; $display("FAIL miss_drain: got rd_en=%b arb=%b, want 0/00", rd_en, arb_state);
    end
  endtask

  task automatic test_timeout;
    wr1_req = 1'b1;
    tick;                 // K+1
    checks++;
    if (wr1_en !== 1'b1 || arb_state !== 2'b10) begin
      errors++; $display("FAIL to_grant: got wr1=%b arb=%b, want 1/10", wr1_en, arb_state);
    end
    repeat (15) tick;     // K+16
    checks++;
    if (wr1_en !== 1'b1 || tout !== 1'b0) begin
      errors++; $display("FAIL to_hold16: got wr1=%b tout=%b, want 1/0", wr1_en, tout);
    end
    tick;                 // K+17
`ifdef SCHED_TIMEOUT_EN
    checks++;
    if (wr1_en !== 1'b0 || tout !== 1'b1 || arb_state !== 2'b11) begin
      errors++; $display("FAIL to_expire: got wr1=%b tout=%b arb=%b, want 0/1/11", wr1_en, tout, arb_state);
    end
    tick;
    checks++;
    if (tout !== 1'b0 || arb_state !== 2'b00) begin
      errors++; $display("FAIL to_pulse_end: got tout=%b arb=%b, want 0/00", tout, arb_state);
    end
    tick;
    checks++;
    if (wr1_en !== 1'b1) begin errors++; $display("FAIL to_regrant: got wr1=%b, want 1", wr1_en); end
`else
    repeat (20) tick;
    checks++;
    if (wr1_en !== 1'b1 || tout !== 1'b0) begin
      errors++; $display("FAIL no_timeout_hold: got wr1=%b tout=%b, want 1/0", wr1_en, tout);
    end
`endif
    wr1_req = 1'b0; wr1_donep = 1'b1;
    tick;
    wr1_donep = 1'b0;
    tick; tick;
  endtask

  task automatic test_reset_mid_grant;
    wr0_req = 1'b1;
    tick;
    checks++;
    if (wr0_en !== 1'b1) begin errors++; $display("FAIL rst_pre_grant: got wr0=%b, want 1", wr0_en); end
    wr1_req = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({rd_en, wr0_en, wr1_en, arb_state, rd_miss, miss_cnt, tout} !== 14'd0) begin
      errors++;
      $display("FAIL rst_mid_grant: got en=%b%b%b arb=%b miss=%b cnt=%0d tout=%b, want all zero",
               rd_en, wr0_en, wr1_en, arb_state, rd_miss, miss_cnt, tout);
    end
    tick;
    checks++;
    if (wr0_en !== 1'b1 || wr1_en !== 1'b0) begin
      errors++; $display("FAIL rst_rr_ptr: got wr0=%b wr1=%b, want 1/0", wr0_en, wr1_en);
    end
    wr0_req = 1'b0; wr1_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_read_grant;
    test_writer_rr;
    test_read_priority;
    test_miss;
    test_timeout;
    test_reset_mid_grant;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_sched.md
MEM_SCHED -- requirements
Module: mem_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 2048, cycles a grant may be held without a done before forced release.
REQ-002 SHALL have parameter GAP_CYC, default 1, range 1..15, idle cycles inserted between consecutive grants.
REQ-003 SHALL have port pclk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports hs, vs  input  1 each  display line/frame timing in pclk domain, active-high.
REQ-006 SHALL have ports wr0_req, wr1_req  input  1 each  capture writer 0/1 has a burst pending (level).
REQ-007 SHALL have ports rd_donep, wr0_donep, wr1_donep  input  1 each  owner finished its access (level, pclk-synchronous).
REQ-008 SHALL have ports rd_en, wr0_en, wr1_en  output  1 each  grant (memcon_en) to display reader / writer 0 / writer 1.
REQ-009 SHALL have port arb_state  output  2  owner code: 00 reader-or-idle, 01 writer 0, 10 writer 1, 11 gap.
REQ-010 SHALL have ports rd_miss  output  1 (pulse) and miss_cnt  output  8  underrun indication and saturating count.
REQ-011 SHALL have port tout  output  1  one-cycle pulse on forced release.

Function
REQ-012 SHALL register hs and vs; line edge = hs high and hs_q low; frame edge = vs high and vs_q low.
REQ-013 SHALL set rd_pend in the cycle after a line edge; rd_pend clears when rd_en is granted.
REQ-014 SHALL implement states IDLE, RD, WR0, WR1, GAP; exactly one of rd_en/wr0_en/wr1_en high in RD/WR0/WR1, all low in IDLE/GAP.
REQ-015 SHALL in IDLE grant by priority: rd_pend > writers; between writers round-robin, last-served writer lowest priority.
REQ-016 SHALL assert the grant the cycle after the IDLE decision; from an idle line edge in cycle N, rd_en is high in cycle N+2.
REQ-017 SHALL hold a grant until its donep is sampled high in cycle M; enable low in M+1, state GAP for GAP_CYC cycles, then IDLE.
REQ-018 SHALL not grant a writer whose req is low; a writer dropping req mid-grant does not end the grant.
REQ-019 SHALL drive arb_state 00 in IDLE and RD, 01 in WR0, 10 in WR1, 11 in GAP.
REQ-020 SHALL pulse rd_miss for one cycle when a line edge occurs while rd_pend is already set or state is RD; miss_cnt increments, saturating at 255.
REQ-021 SHALL on frame edge clear miss_cnt to 0 (a coincident miss counts as 1 after clear) and leave any active grant untouched.
REQ-022 SHALL when donep and a line edge coincide: release per REQ-017, set rd_pend, no miss unless REQ-020 applies.
REQ-023 SHALL ignore donep inputs not belonging to the current owner.

Reset
REQ-024 SHALL on rst: state IDLE, all enables 0, arb_state 00, rd_pend 0, rd_miss 0, miss_cnt 0, tout 0, round-robin pointer to writer 0, hs_q/vs_q 0.
REQ-025 SHALL on rst asserted mid-grant drop the enable in the next cycle with no GAP sequencing.

Configuration
REQ-026 SHALL with macro SCHED_TIMEOUT_EN defined count grant cycles; on reaching TIMEOUT without donep, drop the enable, pulse tout, enter GAP.
REQ-027 SHALL without SCHED_TIMEOUT_EN hold grants indefinitely until donep, tout tied 0, no timeout counter synthesized.

Verification
REQ-028 SHALL cover: idle, hs rising in cycle 10 -> rd_en high at cycle 12, arb_state 00; rd_donep at 20 -> rd_en low at 21, arb_state 11 at 21, IDLE at 22.
REQ-029 SHALL cover: wr0_req and wr1_req held high, no hs -> grants alternate WR0, WR1, WR0 with arb_state 01/10 and GAP_CYC=1 gap between each.
REQ-030 SHALL cover: WR0 active, line edge arrives -> after wr0_donep next grant is RD even with wr1_req high.
REQ-031 SHALL cover: RD held without done across 3 line edges -> 3 rd_miss pulses, miss_cnt=3; vs rising -> miss_cnt=0.
REQ-032 SHALL cover: SCHED_TIMEOUT_EN, TIMEOUT=16, wr1 granted never done -> wr1_en low after 16 cycles, tout pulse, GAP then next grant; without macro wr1_en stays high.
REQ-033 SHALL cover: rst asserted during WR0 grant -> wr0_en 0 next cycle, all outputs at reset values.
